matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences the 16x16 composed systolic matmul over a larger problem of M x N output tiles with K accumulation chunks per output tile.
- For each step it issues pe_reset, start_mat_mul, per-tile A/B/C base addresses, strides and validity masks, then waits for done_mat_mul.
- Sits between the host/CSR interface and the composed matmul instance.

Parameters:
AWIDTH, 10, SRAM address width (matches the matmul address ports)
ADDR_STRIDE_WIDTH, 8, address stride width
MASK_WIDTH, 16, validity mask width (one bit per row/column of the 16x16 array)
CNT_WIDTH, 8, tile counter width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  host start; sampled in IDLE only
cfg_tiles_m / cfg_tiles_n / cfg_tiles_k  in  CNT_WIDTH each  tile counts
cfg_base_a / cfg_base_b / cfg_base_c  in  AWIDTH each  base addresses
cfg_step_a_m, cfg_step_a_k, cfg_step_b_k, cfg_step_b_n, cfg_step_c_m, cfg_step_c_n  in  AWIDTH each  per-tile address increments
cfg_stride_a / cfg_stride_b / cfg_stride_c  in  ADDR_STRIDE_WIDTH each  stride passthrough
cfg_last_row_mask / cfg_last_k_mask / cfg_last_col_mask  in  MASK_WIDTH each  edge-tile masks
busy  out  1  high from LOAD through DONE
done  out  1  one-cycle pulse at job end
cfg_err  out  1  sticky; set on zero tile count
mm_pe_reset  out  1  to pe_reset
mm_start  out  1  to start_mat_mul
mm_done  in  1  from done_mat_mul
mm_addr_a / mm_addr_b / mm_addr_c  out  AWIDTH each  to address_mat_a/b/c
mm_stride_a / mm_stride_b / mm_stride_c  out  ADDR_STRIDE_WIDTH each  registered strides
mm_mask_a_rows / mm_mask_a_cols_b_rows / mm_mask_b_cols  out  MASK_WIDTH each  validity masks

Behaviour:
- Reset: all outputs 0, masks 0, FSM IDLE, counters i/j/k 0, cfg_err 0. An async reset mid-job aborts immediately; mm_start drops with reset assertion.
- States:
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle): capture all cfg_*; clear cfg_err.
    - If any tile count is 0: set cfg_err, go to DONE.
    - Otherwise: i=j=k=0, address registers = bases, go to PE_RST.
  - PE_RST (1 cycle): mm_pe_reset=1 if k==0 (clears accumulators at the start of each output tile), else 0. Go to RUN.
  - RUN: mm_start=1 (level), held until mm_done=1, then go to DRAIN. mm_start deasserts in the cycle after mm_done is sampled high.
  - DRAIN: mm_start=0; wait for mm_done=0, then go to NEXT.
  - NEXT (1 cycle): advance the loop nest (k innermost, then j, then i).
    - k<K-1: k++, addr_a+=step_a_k, addr_b+=step_b_k.
    - Otherwise k=0 and addr_a/addr_b rewind to the row/column bases:
      - j<N-1: j++, addr_b=base_b+(j+1)*step_b_n, addr_c+=step_c_n.
      - Otherwise j=0:
        - i<M-1: i++, a-row base+=step_a_m, c-row base+=step_c_m, addr_c=new c-row base.
        - i=M-1: job complete, go to DONE.
    - Any advance goes to PE_RST.
  - DONE (1 cycle): done=1, busy=0 next cycle, go to IDLE.
- Addressing: all address updates are incremental (adders only, no multipliers). Row/column base registers are held for rewinds. Arithmetic wraps modulo 2^AWIDTH.
- mm_addr_*, strides and masks are registered and stable for the whole PE_RST..DRAIN window of each step.
- Masks, all ones unless at an edge:
  - mm_mask_a_rows = cfg_last_row_mask when i==M-1.
  - mm_mask_a_cols_b_rows = cfg_last_k_mask when k==K-1.
  - mm_mask_b_cols = cfg_last_col_mask when j==N-1.
- Conditions ORed on the same step: M=1 with K=1 applies both the row mask and the k mask.
- start while busy: ignored. cfg_* changes after LOAD: no effect.
- Total matmul invocations per job = M*N*K. Each invocation costs (matmul latency + 3 + DRAIN wait) cycles.

Test Plan:
- M=N=K=1, bases A=0x010, B=0x020, C=0x030, matmul model done after 20 cycles:
  - pe_reset pulses once, then mm_start is high for 20 cycles.
  - Addresses equal the bases; all three masks take their cfg_last_* values.
  - done pulses once; busy is low afterwards.
- M=1, N=1, K=3, step_a_k=0x8, step_b_k=0x80:
  - mm_addr_a sequence is 0x010, 0x018, 0x020; mm_addr_b is 0x020, 0x0A0, 0x120.
  - pe_reset asserts only before the first step.
  - mm_addr_c is constant.
- M=2, N=2, K=1, step_c_n=0x10, step_c_m=0x100:
  - mm_addr_c sequence is 0x030, 0x040, 0x130, 0x140.
  - pe_reset before each of the 4 steps.
  - Exactly 4 mm_start rising edges.
- cfg_tiles_k=0: cfg_err=1, done pulses within 3 cycles of start, mm_start never asserts.
- mm_done held high for 5 cycles: scheduler stays in DRAIN, the next mm_start rises only after mm_done falls, and no step is double-counted.
- resetn low during RUN of step 2 of 4: mm_start, busy and masks go to 0 asynchronously. A new start after release runs the full job from step 0.

Source files
------------

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler
// Walks an M x N grid of output tiles, each accumulated over K chunks, and
// drives one invocation of the 16x16 composed systolic matmul per chunk.
// Each step issues pe_reset (on the first chunk of a tile), then holds
// start_mat_mul high until done_mat_mul, then waits for done to fall.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start                host start, honoured only while idle
//   cfg_tiles_m/n/k      tile counts (zero in any -> cfg_err)
//   cfg_base_a/b/c       base addresses of the A, B and C operands
//   cfg_step_*           per-tile address increments
//   cfg_stride_a/b/c     strides passed through to the matmul
//   cfg_last_*_mask      validity masks applied on edge tiles
//   busy, done, cfg_err  job status
//   mm_*                 interface to the composed matmul instance
module matmul_tile_scheduler #(
  parameter int unsigned AWIDTH            = 10,
  parameter int unsigned ADDR_STRIDE_WIDTH = 8,
  parameter int unsigned MASK_WIDTH        = 16,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_tiles_m,
  input  logic [CNT_WIDTH-1:0]         cfg_tiles_n,
  input  logic [CNT_WIDTH-1:0]         cfg_tiles_k,
  input  logic [AWIDTH-1:0]            cfg_base_a,
  input  logic [AWIDTH-1:0]            cfg_base_b,
  input  logic [AWIDTH-1:0]            cfg_base_c,
  input  logic [AWIDTH-1:0]            cfg_step_a_m,
  input  logic [AWIDTH-1:0]            cfg_step_a_k,
  input  logic [AWIDTH-1:0]            cfg_step_b_k,
  input  logic [AWIDTH-1:0]            cfg_step_b_n,
  input  logic [AWIDTH-1:0]            cfg_step_c_m,
  input  logic [AWIDTH-1:0]            cfg_step_c_n,
  input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_a,
  input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_b,
  input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_c,
  input  logic [MASK_WIDTH-1:0]        cfg_last_row_mask,
  input  logic [MASK_WIDTH-1:0]        cfg_last_k_mask,
  input  logic [MASK_WIDTH-1:0]        cfg_last_col_mask,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         mm_pe_reset,
  output logic                         mm_start,
  input  logic                         mm_done,
  output logic [AWIDTH-1:0]            mm_addr_a,
  output logic [AWIDTH-1:0]            mm_addr_b,
  output logic [AWIDTH-1:0]            mm_addr_c,
  output logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_a,
  output logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_b,
  output logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_c,
  output logic [MASK_WIDTH-1:0]        mm_mask_a_rows,
  output logic [MASK_WIDTH-1:0]        mm_mask_a_cols_b_rows,
  output logic [MASK_WIDTH-1:0]        mm_mask_b_cols
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PE_RST = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [2:0]                   r_state;
  logic [CNT_WIDTH-1:0]         r_i, r_j, r_k;
  logic [CNT_WIDTH-1:0]         r_cnt_m, r_cnt_n, r_cnt_k;
  logic [AWIDTH-1:0]            r_base_b;
  logic [AWIDTH-1:0]            r_step_a_m, r_step_a_k, r_step_b_k;
  logic [AWIDTH-1:0]            r_step_b_n, r_step_c_m, r_step_c_n;
  logic [MASK_WIDTH-1:0]        r_last_row, r_last_k, r_last_col;
  logic [AWIDTH-1:0]            r_a_row_base, r_b_col_base, r_c_row_base;
  logic [AWIDTH-1:0]            r_addr_a, r_addr_b, r_addr_c;
  logic [ADDR_STRIDE_WIDTH-1:0] r_stride_a, r_stride_b, r_stride_c;
  logic [MASK_WIDTH-1:0]        r_mask_a, r_mask_ab, r_mask_b;
  logic                         r_cfg_err;

  logic                         w_zero;
  logic                         w_k_last, w_j_last, w_i_last, w_job_end;
  logic [CNT_WIDTH-1:0]         w_i_n, w_j_n, w_k_n;
  logic [CNT_WIDTH-1:0]         w_mi, w_mj, w_mk, w_cm, w_cn, w_ck;
  logic [MASK_WIDTH-1:0]        w_lrow, w_lk, w_lcol;
  logic [MASK_WIDTH-1:0]        w_mask_a_n, w_mask_ab_n, w_mask_b_n;
  logic [AWIDTH-1:0]            w_a_row_inc, w_b_col_inc, w_c_row_inc;

  assign w_zero = (cfg_tiles_m == '0) || (cfg_tiles_n == '0) || (cfg_tiles_k == '0);

  assign w_k_last = (r_k == r_cnt_k - CntOne);
  assign w_j_last = (r_j == r_cnt_n - CntOne);
  assign w_i_last = (r_i == r_cnt_m - CntOne);

  assign w_a_row_inc = r_a_row_base + r_step_a_m;
  assign w_b_col_inc = r_b_col_base + r_step_b_n;
  assign w_c_row_inc = r_c_row_base + r_step_c_m;

  // Loop nest advance, k innermost.
  always_comb begin
    w_i_n     = r_i;
    w_j_n     = r_j;
    w_k_n     = r_k;
    w_job_end = 1'b0;
    if (!w_k_last) begin
      w_k_n = r_k + CntOne;
    end else begin
      w_k_n = '0;
      if (!w_j_last) begin
        w_j_n = r_j + CntOne;
      end else begin
        w_j_n = '0;
        if (!w_i_last) begin
          w_i_n = r_i + CntOne;
        end else begin
          w_job_end = 1'b1;
        end
      end
    end
  end

  // Masks for the step about to be issued: from the live cfg in LOAD (indices all zero),
  // from the captured cfg and the advanced indices in NEXT.
  always_comb begin
    if (r_state == S_LOAD) begin
      w_mi   = '0;
      w_mj   = '0;
      w_mk   = '0;
      w_cm   = cfg_tiles_m;
      w_cn   = cfg_tiles_n;
      w_ck   = cfg_tiles_k;
      w_lrow = cfg_last_row_mask;
      w_lk   = cfg_last_k_mask;
      w_lcol = cfg_last_col_mask;
    end else begin
      w_mi   = w_i_n;
      w_mj   = w_j_n;
      w_mk   = w_k_n;
      w_cm   = r_cnt_m;
      w_cn   = r_cnt_n;
      w_ck   = r_cnt_k;
      w_lrow = r_last_row;
      w_lk   = r_last_k;
      w_lcol = r_last_col;
    end
    w_mask_a_n  = (w_mi == w_cm - CntOne) ? w_lrow : '1;
    w_mask_ab_n = (w_mk == w_ck - CntOne) ? w_lk   : '1;
    w_mask_b_n  = (w_mj == w_cn - CntOne) ? w_lcol : '1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_cnt_m      <= '0;
      r_cnt_n      <= '0;
      r_cnt_k      <= '0;
      r_base_b     <= '0;
      r_step_a_m   <= '0;
      r_step_a_k   <= '0;
      r_step_b_k   <= '0;
      r_step_b_n   <= '0;
      r_step_c_m   <= '0;
      r_step_c_n   <= '0;
      r_last_row   <= '0;
      r_last_k     <= '0;
      r_last_col   <= '0;
      r_a_row_base <= '0;
      r_b_col_base <= '0;
      r_c_row_base <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_addr_c     <= '0;
      r_stride_a   <= '0;
      r_stride_b   <= '0;
      r_stride_c   <= '0;
      r_mask_a     <= '0;
      r_mask_ab    <= '0;
      r_mask_b     <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_cnt_m    <= cfg_tiles_m;
          r_cnt_n    <= cfg_tiles_n;
          r_cnt_k    <= cfg_tiles_k;
          r_base_b   <= cfg_base_b;
          r_step_a_m <= cfg_step_a_m;
          r_step_a_k <= cfg_step_a_k;
          r_step_b_k <= cfg_step_b_k;
          r_step_b_n <= cfg_step_b_n;
          r_step_c_m <= cfg_step_c_m;
          r_step_c_n <= cfg_step_c_n;
          r_last_row <= cfg_last_row_mask;
          r_last_k   <= cfg_last_k_mask;
          r_last_col <= cfg_last_col_mask;
          r_stride_a <= cfg_stride_a;
          r_stride_b <= cfg_stride_b;
          r_stride_c <= cfg_stride_c;
          r_cfg_err  <= w_zero;
          if (w_zero) begin
            r_state <= S_DONE;
          end else begin
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_a_row_base <= cfg_base_a;
            r_b_col_base <= cfg_base_b;
            r_c_row_base <= cfg_base_c;
            r_addr_a     <= cfg_base_a;
            r_addr_b     <= cfg_base_b;
            r_addr_c     <= cfg_base_c;
            r_mask_a     <= w_mask_a_n;
            r_mask_ab    <= w_mask_ab_n;
            r_mask_b     <= w_mask_b_n;
            r_state      <= S_PE_RST;
          end
        end
        S_PE_RST: r_state <= S_RUN;
        S_RUN: begin
          if (mm_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!mm_done) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_job_end) begin
            r_state <= S_DONE;
          end else begin
            r_i       <= w_i_n;
            r_j       <= w_j_n;
            r_k       <= w_k_n;
            r_mask_a  <= w_mask_a_n;
            r_mask_ab <= w_mask_ab_n;
            r_mask_b  <= w_mask_b_n;
            if (!w_k_last) begin
              r_addr_a <= r_addr_a + r_step_a_k;
              r_addr_b <= r_addr_b + r_step_b_k;
            end else if (!w_j_last) begin
              // Next column tile: A rewinds to its row base, B moves to the next column.
              r_addr_a     <= r_a_row_base;
              r_b_col_base <= w_b_col_inc;
              r_addr_b     <= w_b_col_inc;
              r_addr_c     <= r_addr_c + r_step_c_n;
            end else begin
              // Next row tile: B rewinds to its base, A and C move down one row.
              r_a_row_base <= w_a_row_inc;
              r_addr_a     <= w_a_row_inc;
              r_b_col_base <= r_base_b;
              r_addr_b     <= r_base_b;
              r_c_row_base <= w_c_row_inc;
              r_addr_c     <= w_c_row_inc;
            end
            r_state <= S_PE_RST;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control strobes decode straight from the state register so an async reset drops them.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mm_start    = (r_state == S_RUN);
  assign mm_pe_reset = (r_state == S_PE_RST) && (r_k == '0);
  assign cfg_err     = r_cfg_err;

  assign mm_addr_a             = r_addr_a;
  assign mm_addr_b             = r_addr_b;
  assign mm_addr_c             = r_addr_c;
  assign mm_stride_a           = r_stride_a;
  assign mm_stride_b           = r_stride_b;
  assign mm_stride_c           = r_stride_c;
  assign mm_mask_a_rows        = r_mask_a;
  assign mm_mask_a_cols_b_rows = r_mask_ab;
  assign mm_mask_b_cols        = r_mask_b;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: table of jobs plus random jobs,
// each compared step by step against a loop-nest reference model, and an
// asynchronous mid-job reset sequence.
module tb_matmul_tile_scheduler;

  localparam int AW = 10;
  localparam int SW = 8;
  localparam int MW = 16;
  localparam int CW = 8;
  localparam int TIMEOUT = 5000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] cfg_tiles_m, cfg_tiles_n, cfg_tiles_k;
  logic [AW-1:0] cfg_base_a, cfg_base_b, cfg_base_c;
  logic [AW-1:0] cfg_step_a_m, cfg_step_a_k, cfg_step_b_k;
  logic [AW-1:0] cfg_step_b_n, cfg_step_c_m, cfg_step_c_n;
  logic [SW-1:0] cfg_stride_a, cfg_stride_b, cfg_stride_c;
  logic [MW-1:0] cfg_last_row_mask, cfg_last_k_mask, cfg_last_col_mask;
  logic          busy, done, cfg_err, mm_pe_reset, mm_start, mm_done;
  logic [AW-1:0] mm_addr_a, mm_addr_b, mm_addr_c;
  logic [SW-1:0] mm_stride_a, mm_stride_b, mm_stride_c;
  logic [MW-1:0] mm_mask_a_rows, mm_mask_a_cols_b_rows, mm_mask_b_cols;

  matmul_tile_scheduler #(
    .AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW), .MASK_WIDTH(MW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_tiles_m(cfg_tiles_m), .cfg_tiles_n(cfg_tiles_n), .cfg_tiles_k(cfg_tiles_k),
    .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
    .cfg_step_a_m(cfg_step_a_m), .cfg_step_a_k(cfg_step_a_k), .cfg_step_b_k(cfg_step_b_k),
    .cfg_step_b_n(cfg_step_b_n), .cfg_step_c_m(cfg_step_c_m), .cfg_step_c_n(cfg_step_c_n),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_stride_c(cfg_stride_c),
    .cfg_last_row_mask(cfg_last_row_mask), .cfg_last_k_mask(cfg_last_k_mask),
    .cfg_last_col_mask(cfg_last_col_mask),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mm_pe_reset(mm_pe_reset), .mm_start(mm_start), .mm_done(mm_done),
    .mm_addr_a(mm_addr_a), .mm_addr_b(mm_addr_b), .mm_addr_c(mm_addr_c),
    .mm_stride_a(mm_stride_a), .mm_stride_b(mm_stride_b), .mm_stride_c(mm_stride_c),
    .mm_mask_a_rows(mm_mask_a_rows), .mm_mask_a_cols_b_rows(mm_mask_a_cols_b_rows),
    .mm_mask_b_cols(mm_mask_b_cols)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            m, n, k;
    logic [AW-1:0] base_a, base_b, base_c;
    logic [AW-1:0] sam, sak, sbk, sbn, scm, scn;
    logic [SW-1:0] sa, sb, sc;
    logic [MW-1:0] lrow, lk, lcol;
    int            lat, hold;
    bit            exp_err;
    int            exp_steps;
    logic [AW-1:0] last_a, last_b, last_c;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a, b, c;
    logic [MW-1:0] ma, mk, mb;
    bit            pe;
  } step_t;

  step_t got_q[$];
  step_t exp_q[$];
  vec_t  vecs[6];

  int n_checks = 0;
  int n_errors = 0;
  int r_lat    = 1;
  int r_hold   = 1;
  int stab_err, early_start, pe_with_start, start_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Matmul stand-in: done rises after r_lat cycles of mm_start and stays high r_hold cycles.
  initial begin : responder
    int cnt;
    int h;
    mm_done = 1'b0;
    cnt = 0;
    h = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mm_done = 1'b0;
        cnt = 0;
        h = 0;
      end else if (h > 0) begin
        h--;
        if (h == 0) mm_done = 1'b0;
      end else if (mm_start) begin
        cnt++;
        if (cnt >= r_lat) begin
          mm_done = 1'b1;
          h = r_hold;
          cnt = 0;
        end
      end
    end
  end

  // Records the issued parameters at every mm_start rising edge.
  initial begin : monitor
    bit    prev_s;
    bit    pend;
    step_t cur;
    prev_s = 1'b0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        prev_s = 1'b0;
        pend = 1'b0;
      end else begin
        if (mm_pe_reset) begin
          pend = 1'b1;
          if (mm_start) pe_with_start++;
        end
        if (mm_start) start_cycles++;
        if (mm_start && !prev_s) begin
          cur.a  = mm_addr_a;
          cur.b  = mm_addr_b;
          cur.c  = mm_addr_c;
          cur.ma = mm_mask_a_rows;
          cur.mk = mm_mask_a_cols_b_rows;
          cur.mb = mm_mask_b_cols;
          cur.pe = pend;
          pend = 1'b0;
          got_q.push_back(cur);
          if (mm_done) early_start++;
        end else if (mm_start && got_q.size() > 0) begin
          if (mm_addr_a !== got_q[$].a || mm_addr_b !== got_q[$].b ||
              mm_addr_c !== got_q[$].c || mm_mask_a_rows !== got_q[$].ma ||
              mm_mask_a_cols_b_rows !== got_q[$].mk || mm_mask_b_cols !== got_q[$].mb)
            stab_err++;
        end
        prev_s = mm_start;
      end
    end
  end

  // Reference: the plain M x N x K loop nest with closed-form addresses.
  task automatic build_exp(input vec_t v);
    step_t s;
    exp_q.delete();
    for (int i = 0; i < v.m; i++)
      for (int j = 0; j < v.n; j++)
        for (int k = 0; k < v.k; k++) begin
          s.a  = AW'(int'(v.base_a) + int'(v.sam) * i + int'(v.sak) * k);
          s.b  = AW'(int'(v.base_b) + int'(v.sbn) * j + int'(v.sbk) * k);
          s.c  = AW'(int'(v.base_c) + int'(v.scm) * i + int'(v.scn) * j);
          s.ma = (i == v.m - 1) ? v.lrow : '1;
          s.mk = (k == v.k - 1) ? v.lk : '1;
          s.mb = (j == v.n - 1) ? v.lcol : '1;
          s.pe = (k == 0);
          exp_q.push_back(s);
        end
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_tiles_m = CW'(v.m);
    cfg_tiles_n = CW'(v.n);
    cfg_tiles_k = CW'(v.k);
    cfg_base_a = v.base_a;
    cfg_base_b = v.base_b;
    cfg_base_c = v.base_c;
    cfg_step_a_m = v.sam;
    cfg_step_a_k = v.sak;
    cfg_step_b_k = v.sbk;
    cfg_step_b_n = v.sbn;
    cfg_step_c_m = v.scm;
    cfg_step_c_n = v.scn;
    cfg_stride_a = v.sa;
    cfg_stride_b = v.sb;
    cfg_stride_c = v.sc;
    cfg_last_row_mask = v.lrow;
    cfg_last_k_mask = v.lk;
    cfg_last_col_mask = v.lcol;
  endtask

  task automatic scramble_cfg();
    cfg_tiles_m = CW'($urandom);
    cfg_tiles_n = CW'($urandom);
    cfg_tiles_k = CW'($urandom);
    cfg_base_a = AW'($urandom);
    cfg_base_b = AW'($urandom);
    cfg_base_c = AW'($urandom);
    cfg_step_a_m = AW'($urandom);
    cfg_step_a_k = AW'($urandom);
    cfg_step_b_k = AW'($urandom);
    cfg_step_b_n = AW'($urandom);
    cfg_step_c_m = AW'($urandom);
    cfg_step_c_n = AW'($urandom);
    cfg_stride_a = SW'($urandom);
    cfg_stride_b = SW'($urandom);
    cfg_stride_c = SW'($urandom);
    cfg_last_row_mask = MW'($urandom);
    cfg_last_k_mask = MW'($urandom);
    cfg_last_col_mask = MW'($urandom);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int cyc;
    bit got;
    int n;
    r_lat = v.lat;
    r_hold = v.hold;
    drive_cfg(v);
    build_exp(v);
    @(negedge clk);
    got_q.delete();
    stab_err = 0;
    early_start = 0;
    pe_with_start = 0;
    start_cycles = 0;
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) scramble_cfg();        // captured already; must not matter
      if (cyc == 3 && !v.exp_err) start = 1'b1;  // ignored while busy
      if (cyc == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, " done seen"}, 64'(got), 64'd1);
    if (v.exp_err) check({tag, " err done latency<=3"}, 64'(cyc <= 3), 64'd1);
    check({tag, " cfg_err"}, 64'(cfg_err), 64'(v.exp_err));
    @(negedge clk);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    check({tag, " done single pulse"}, 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, " no restart"}, 64'(busy), 64'd0);
    check({tag, " step count"}, 64'(got_q.size()), 64'(v.exp_steps));
    check({tag, " start high cycles"}, 64'(start_cycles), 64'(v.exp_steps * v.lat));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int s = 0; s < n; s++) begin
      check($sformatf("%s s%0d addr_a", tag, s), 64'(got_q[s].a), 64'(exp_q[s].a));
      check($sformatf("%s s%0d addr_b", tag, s), 64'(got_q[s].b), 64'(exp_q[s].b));
      check($sformatf("%s s%0d addr_c", tag, s), 64'(got_q[s].c), 64'(exp_q[s].c));
      check($sformatf("%s s%0d mask_a", tag, s), 64'(got_q[s].ma), 64'(exp_q[s].ma));
      check($sformatf("%s s%0d mask_k", tag, s), 64'(got_q[s].mk), 64'(exp_q[s].mk));
      check($sformatf("%s s%0d mask_b", tag, s), 64'(got_q[s].mb), 64'(exp_q[s].mb));
      check($sformatf("%s s%0d pe_reset", tag, s), 64'(got_q[s].pe), 64'(exp_q[s].pe));
    end
    if (v.exp_steps > 0 && got_q.size() > 0) begin
      check({tag, " last addr_a"}, 64'(got_q[$].a), 64'(v.last_a));
      check({tag, " last addr_b"}, 64'(got_q[$].b), 64'(v.last_b));
      check({tag, " last addr_c"}, 64'(got_q[$].c), 64'(v.last_c));
    end
    check({tag, " stride_a"}, 64'(mm_stride_a), 64'(v.sa));
    check({tag, " stride_b"}, 64'(mm_stride_b), 64'(v.sb));
    check({tag, " stride_c"}, 64'(mm_stride_c), 64'(v.sc));
    check({tag, " stable in RUN"}, 64'(stab_err), 64'd0);
    check({tag, " start rose while done high"}, 64'(early_start), 64'd0);
    check({tag, " pe_reset with start"}, 64'(pe_with_start), 64'd0);
  endtask

  function automatic vec_t mkvec(int m, int n, int k, int lat, int hold);
    vec_t v;
    v.m = m; v.n = n; v.k = k;
    v.base_a = 10'h010; v.base_b = 10'h020; v.base_c = 10'h030;
    v.sam = '0; v.sak = '0; v.sbk = '0; v.sbn = '0; v.scm = '0; v.scn = '0;
    v.sa = 8'h11; v.sb = 8'h22; v.sc = 8'h33;
    v.lrow = 16'h00FF; v.lk = 16'h0F0F; v.lcol = 16'h3333;
    v.lat = lat; v.hold = hold;
    v.exp_err = 1'b0;
    v.exp_steps = m * n * k;
    v.last_a = 10'h010; v.last_b = 10'h020; v.last_c = 10'h030;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   cyc;
    resetn = 1'b0;
    start = 1'b0;
    drive_cfg(mkvec(1, 1, 1, 1, 1));

    // Table of jobs: inputs plus hand-derived expected totals and final addresses.
    vecs[0] = mkvec(1, 1, 1, 20, 1);
    vecs[1] = mkvec(1, 1, 3, 5, 2);
    vecs[1].sak = 10'h008; vecs[1].sbk = 10'h080;
    vecs[1].last_a = 10'h020; vecs[1].last_b = 10'h120;
    vecs[2] = mkvec(2, 2, 1, 4, 1);
    vecs[2].scn = 10'h010; vecs[2].scm = 10'h100;
    vecs[2].last_c = 10'h140;
    vecs[3] = mkvec(1, 1, 0, 1, 1);
    vecs[3].exp_err = 1'b1; vecs[3].exp_steps = 0;
    vecs[4] = mkvec(2, 2, 2, 3, 5);
    vecs[4].sam = 10'h040; vecs[4].sak = 10'h004; vecs[4].sbk = 10'h002;
    vecs[4].sbn = 10'h020; vecs[4].scm = 10'h100; vecs[4].scn = 10'h008;
    vecs[4].last_a = 10'h054; vecs[4].last_b = 10'h042; vecs[4].last_c = 10'h138;
    vecs[5] = mkvec(1, 1, 2, 2, 2);
    vecs[5].base_a = 10'h3FC; vecs[5].sak = 10'h008;
    vecs[5].last_a = 10'h004;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset cfg_err", 64'(cfg_err), 64'd0);
    check("reset mm_start", 64'(mm_start), 64'd0);
    check("reset mm_pe_reset", 64'(mm_pe_reset), 64'd0);
    check("reset addr_a", 64'(mm_addr_a), 64'd0);
    check("reset mask_a", 64'(mm_mask_a_rows), 64'd0);
    check("reset mask_b", 64'(mm_mask_b_cols), 64'd0);
    check("reset stride_c", 64'(mm_stride_c), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) run_job(vecs[t], $sformatf("vec%0d", t));

    // Random jobs against the loop-nest model.
    for (int r = 0; r < 8; r++) begin
      v = mkvec(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 4)));
      v.base_a = AW'($urandom); v.base_b = AW'($urandom); v.base_c = AW'($urandom);
      v.sam = AW'($urandom); v.sak = AW'($urandom); v.sbk = AW'($urandom);
      v.sbn = AW'($urandom); v.scm = AW'($urandom); v.scn = AW'($urandom);
      v.sa = SW'($urandom); v.sb = SW'($urandom); v.sc = SW'($urandom);
      v.lrow = MW'($urandom); v.lk = MW'($urandom); v.lcol = MW'($urandom);
      v.last_a = AW'(int'(v.base_a) + int'(v.sam) * (v.m - 1) + int'(v.sak) * (v.k - 1));
      v.last_b = AW'(int'(v.base_b) + int'(v.sbn) * (v.n - 1) + int'(v.sbk) * (v.k - 1));
      v.last_c = AW'(int'(v.base_c) + int'(v.scm) * (v.m - 1) + int'(v.scn) * (v.n - 1));
      run_job(v, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the RUN phase of step 2 of 4, then a clean rerun.
    v = vecs[2];
    v.lat = 10;
    r_lat = v.lat;
    r_hold = v.hold;
    drive_cfg(v);
    @(negedge clk);
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (got_q.size() < 2 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("abort reached step 2", 64'(got_q.size()), 64'd2);
    check("abort in RUN", 64'(mm_start), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("abort mm_start", 64'(mm_start), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort mask_a", 64'(mm_mask_a_rows), 64'd0);
    check("abort mask_k", 64'(mm_mask_a_cols_b_rows), 64'd0);
    check("abort mask_b", 64'(mm_mask_b_cols), 64'd0);
    check("abort addr_c", 64'(mm_addr_c), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_job(v, "rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
